// File: rtl/sram_dp_be_if.sv
// Request/response bundle for sram_dp_be: one write port and one read port.
// The master drives the requests and the slave (the RAM) returns read data and valid.
interface sram_dp_be_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 16
);
  logic                    i_wr_en;
  logic [ADDR_WIDTH-1:0]   i_wr_addr;
  logic [WORD_WIDTH-1:0]   i_wr_data;
  logic [WORD_WIDTH/8-1:0] i_wr_be;
  logic                    i_rd_en;
  logic [ADDR_WIDTH-1:0]   i_rd_addr;
  logic [WORD_WIDTH-1:0]   o_rd_data;
  logic                    o_rd_valid;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_wr_be, i_rd_en, i_rd_addr,
    input  o_rd_data, o_rd_valid
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_wr_be, i_rd_en, i_rd_addr,
    output o_rd_data, o_rd_valid
  );
endinterface

// File: rtl/sram_dp_be.sv
// Simple-dual-port RAM with per-byte write enables, 1- or 2-cycle read latency,
// selectable read-during-write result and a read-valid strobe.

module sram_dp_be_lane #(
  parameter int WORD_DEPTH = 4096,
  parameter int IDX_W      = 12
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [7:0]       i_wr_byte,
  input  logic             i_fwd,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [7:0]       o_rd_byte
);
  logic [7:0] r_mem [WORD_DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_byte;
  end

  // i_fwd marks a same-address write on this edge in write-first mode
  assign o_rd_byte = (i_fwd && i_wr_en) ? i_wr_byte : r_mem[i_rd_idx];
endmodule

module sram_dp_be #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_DEPTH = 4096,
  parameter int WORD_WIDTH = 16,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  sram_dp_be_if.slave  bus
);
  localparam int BE_WIDTH = WORD_WIDTH / 8;
  localparam int IDX_W    = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(WORD_DEPTH);

  if ((WORD_WIDTH % 8) != 0 || WORD_WIDTH < 8) begin : g_bad_width
    $fatal(1, "sram_dp_be: WORD_WIDTH must be a non-zero multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "sram_dp_be: RD_LATENCY must be 1 or 2");
  end
  if (WORD_DEPTH < 1 || longint'(WORD_DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
    $fatal(1, "sram_dp_be: WORD_DEPTH must be in 1..2**ADDR_WIDTH");
  end
  if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
    $fatal(1, "sram_dp_be: RDW_MODE must be 0 or 1");
  end

  logic                         w_wr_in, w_rd_in, w_wr_ok, w_fwd;
  logic [IDX_W-1:0]             w_wr_idx, w_rd_idx;
  logic [BE_WIDTH-1:0][7:0]     w_rd_word;
  logic [RD_LATENCY:1]          r_vld_pipe;
  logic [RD_LATENCY:1][WORD_WIDTH-1:0] r_dat_pipe;

  assign w_wr_in  = {1'b0, bus.i_wr_addr} < DEPTH_L;
  assign w_rd_in  = {1'b0, bus.i_rd_addr} < DEPTH_L;
  // Out-of-range writes are dropped outright, so a truncated index never aliases
  assign w_wr_ok  = rst_n & bus.i_wr_en & w_wr_in;
  assign w_wr_idx = bus.i_wr_addr[IDX_W-1:0];
  assign w_rd_idx = bus.i_rd_addr[IDX_W-1:0];
  assign w_fwd    = (RDW_MODE == 1) && w_wr_ok && (bus.i_wr_addr == bus.i_rd_addr);

  for (genvar n = 0; n < BE_WIDTH; n++) begin : g_lane
    sram_dp_be_lane #(
      .WORD_DEPTH (WORD_DEPTH),
      .IDX_W      (IDX_W)
    ) u_lane (
      .clk       (clk),
      .i_wr_en   (w_wr_ok & bus.i_wr_be[n]),
      .i_wr_idx  (w_wr_idx),
      .i_wr_byte (bus.i_wr_data[8*n +: 8]),
      .i_fwd     (w_fwd),
      .i_rd_idx  (w_rd_idx),
      .o_rd_byte (w_rd_word[n])
    );
  end

  // Data stages only load when a result passes through, so the output holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= bus.i_rd_en;
      if (bus.i_rd_en) r_dat_pipe[1] <= w_rd_in ? w_rd_word : '0;
      for (int s = 2; s <= RD_LATENCY; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        if (r_vld_pipe[s-1]) r_dat_pipe[s] <= r_dat_pipe[s-1];
      end
    end
  end

  assign bus.o_rd_data  = r_dat_pipe[RD_LATENCY];
  assign bus.o_rd_valid = r_vld_pipe[RD_LATENCY];
endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
- Parametrised simple-dual-port SRAM: one write port and one independent read port, both on one clock.
- Adds per-byte write enables, selectable read latency, defined read-during-write behaviour and a read-valid strobe.
- Drop-in successor for the CPU's single-port 4096x16 word memory; usable as instruction/data RAM or register-file backing store.

Parameters:
- ADDR_WIDTH, 12, address bits on both ports.
- WORD_DEPTH, 4096, number of words. Must be <= 2^ADDR_WIDTH.
- WORD_WIDTH, 16, bits per word. Must be a multiple of 8; BE_WIDTH = WORD_WIDTH/8 is derived internally.
- RD_LATENCY, 1, cycles from read request to data/valid. Legal values 1 or 2; 2 adds an output register stage.
- RDW_MODE, 0, same-address read during write: 0 = read-first (old data), 1 = write-first (merged new data).

Ports:
- clk, input, 1, single clock, all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- i_wr_en, input, 1, write request this cycle.
- i_wr_addr, input, ADDR_WIDTH, write word address.
- i_wr_data, input, WORD_WIDTH, write data.
- i_wr_be, input, WORD_WIDTH/8, byte enables; bit n covers data bits [8n+7:8n].
- i_rd_en, input, 1, read request this cycle.
- i_rd_addr, input, ADDR_WIDTH, read word address.
- o_rd_data, output, WORD_WIDTH, read data.
- o_rd_valid, output, 1, o_rd_data holds the result of a read request this cycle.

Behaviour:
- Reset is asserted asynchronously by rst_n low:
  - o_rd_data = 0, o_rd_valid = 0, all pipeline data/valid registers = 0.
  - Memory array is NOT cleared.
  - Writes presented while rst_n is low are ignored.
  - Release is synchronous to the next rising edge.
- Write:
  - On an edge with i_wr_en=1 and i_wr_addr < WORD_DEPTH, each byte n with i_wr_be[n]=1 is updated from i_wr_data; bytes with be=0 keep their old value.
  - i_wr_be = 0 is a no-op.
  - i_wr_addr >= WORD_DEPTH: the write is dropped and no other word is modified (no aliasing).
- Read:
  - A request sampled at edge k (i_rd_en=1) produces o_rd_data and o_rd_valid=1 after edge k+RD_LATENCY-1. RD_LATENCY=1 means valid in the cycle after the request edge; RD_LATENCY=2 means one cycle later.
  - Back-to-back requests give back-to-back valid results, fully pipelined, with no stalls.
  - Cycles without a request produce o_rd_valid=0 at the matching output slot.
  - o_rd_data holds its last value when no new read completes; it is not zeroed.
  - i_rd_addr >= WORD_DEPTH: o_rd_data = 0, o_rd_valid = 1.
- Read-during-write (same edge, i_wr_en=i_rd_en=1, equal in-range addresses):
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the merged word (enabled bytes from i_wr_data, others from the old word).
  - Different addresses: the ports are fully independent.
- A read of an address written at an earlier edge always returns the written data, regardless of RDW_MODE.
- Reset mid-operation: in-flight reads are discarded and no o_rd_valid is produced for them. The memory keeps all writes completed before reset assertion.
- Illegal parameters (WORD_WIDTH%8 != 0, RD_LATENCY not 1/2, WORD_DEPTH > 2^ADDR_WIDTH) must fail elaboration.

Test Plan:
- Reset check: rst_n low mid-run with reads in flight -> o_rd_valid=0 and o_rd_data=0 immediately (asynchronous). After release, a read of a pre-reset written address returns the stored value.
- Byte enables (W=16): write 0xABCD to addr 5 with be=11, then 0x1234 with be=01 -> read addr 5 gives 0xAB34. Write with be=00 -> still 0xAB34.
- Latency/pipelining, RD_LATENCY=1 and 2: read addrs 0,1,2 on consecutive edges after filling mem[i]=i*3 -> valid pulses for 3 consecutive cycles with data 0,3,6. First valid appears 1 cycle (RD_LATENCY=1) or 2 cycles (RD_LATENCY=2) after the first request edge. A gap in requests gives a matching gap in valid.
- Read-during-write: mem[9]=0x1111, then the same edge writes 0x2222 with be=11 and reads 9 -> RDW_MODE=0 returns 0x1111, RDW_MODE=1 returns 0x2222. With be=10 and RDW_MODE=1 -> returns 0x2211. The next read of 9 returns 0x2222 (or 0x2211 for the be=10 case) in both modes.
- Out of range (ADDR_WIDTH=12, WORD_DEPTH=3000): write 0xFFFF to addr 3500 -> no word in 0..2999 changes (spot-check 3500 mod 3000 = 500 and addr 0). Read addr 3500 -> o_rd_data=0, o_rd_valid=1.
- Independent ports: each cycle, write random addr A and read random addr B≠A for 10k cycles -> every read matches a scoreboard model with zero mismatches.
